// File: rtl/uart_rx_framer.sv
// Frames UART bytes into little-endian words and queues them in a FWFT FIFO.
// Define RX_FRAME_CHECKSUM_EN to add a trailing mod-256 checksum byte per frame.
module uart_rx_framer #(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_valid,
  output logic                    rx_ready,
  output logic [WORD_BYTES*8-1:0] word_out,
  output logic                    word_out_last,
  output logic                    word_out_valid,
  input  logic                    word_out_ready,
  output logic                    frame_done,
  output logic                    frame_error
);

  localparam int W  = WORD_BYTES * 8;
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WORD_BYTES - 1);
  localparam logic [CW-1:0] CNT_HI   = CW'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

`ifdef RX_FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {HDR, PAYLOAD, CSUM} state_t;
`else
  typedef enum logic [1:0] {HDR, PAYLOAD} state_t;
`endif

  state_t        state_q, state_d;
  logic          rxv_q, rxv_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [W-1:0]  asm_q, asm_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
`ifdef RX_FRAME_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
  logic          err_q, err_d;
`endif

  logic [W:0] mem [FIFO_DEPTH];
  logic       accept;
  logic       push_req;
  logic       push_last;
  logic       push;
  logic       pop;
  logic       full;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    done_d    = 1'b0;
    push_req  = 1'b0;
    push_last = 1'b0;
    rxv_d     = rx_data_valid;
    accept    = rx_data_valid & ~rxv_q;
`ifdef RX_FRAME_CHECKSUM_EN
    sum_d     = sum_q;
    err_d     = 1'b0;
`endif
    if (accept) begin
      unique case (state_q)
        HDR: begin
          if (rx_data != 8'd0) begin
            cnt_d   = rx_data;
            idx_d   = '0;
            state_d = PAYLOAD;
`ifdef RX_FRAME_CHECKSUM_EN
            sum_d   = sum_q + rx_data;
`endif
          end
        end
        PAYLOAD: begin
          asm_d[int'(idx_q) * 8 +: 8] = rx_data;
`ifdef RX_FRAME_CHECKSUM_EN
          sum_d = sum_q + rx_data;
`endif
          if (idx_q == IDX_LAST) begin
            push_req  = 1'b1;
            push_last = (cnt_q == 8'd1);
            idx_d     = '0;
            cnt_d     = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
`ifdef RX_FRAME_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = HDR;
              done_d  = 1'b1;
`endif
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
`ifdef RX_FRAME_CHECKSUM_EN
        CSUM: begin
          done_d  = 1'b1;
          err_d   = (rx_data != sum_q);
          sum_d   = 8'd0;
          state_d = HDR;
        end
`endif
        default: state_d = HDR;
      endcase
    end

    // A full FIFO still accepts a push when the head leaves this cycle.
    pop  = (count_q != '0) & word_out_ready;
    full = (count_q == CNT_FULL);
    push = push_req & (~full | pop);

    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d <= CNT_HI);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HDR;
      rxv_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= 8'd0;
      asm_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
      sum_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rxv_q   <= rxv_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
`ifdef RX_FRAME_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_q] <= {push_last, asm_d};
    end
  end

  assign word_out       = mem[rd_q][W-1:0];
  assign word_out_last  = mem[rd_q][W];
  assign word_out_valid = (count_q != '0);
  assign rx_ready       = ready_q;
  assign frame_done     = done_q;
`ifdef RX_FRAME_CHECKSUM_EN
  assign frame_error    = err_q;
`else
  assign frame_error    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer (WORD_BYTES=4, FIFO_DEPTH=8).
// Honours RX_FRAME_CHECKSUM_EN by appending checksum bytes.
module tb_uart_rx_framer;

  logic        clock;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_ready;
  logic [31:0] word_out;
  logic        word_out_last;
  logic        word_out_valid;
  logic        word_out_ready;
  logic        frame_done;
  logic        frame_error;

  uart_rx_framer #(.WORD_BYTES(4), .FIFO_DEPTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_ready       (rx_ready),
    .word_out       (word_out),
    .word_out_last  (word_out_last),
    .word_out_valid (word_out_valid),
    .word_out_ready (word_out_ready),
    .frame_done     (frame_done),
    .frame_error    (frame_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  b [10];
    int          nb;
    int          nw;
    logic [32:0] w [2];
    int          ndone;
  } vec_t;

  vec_t        vt [4];
  int          n_tests;
  int          n_fail;
  logic [32:0] got_q [$];
  int          n_done;
  int          n_err;
  logic        mon_clr;
  logic [7:0]  fb [$];

  always @(negedge clock) begin
    if (mon_clr) begin
      got_q.delete();
      n_done = 0;
      n_err  = 0;
    end else if (!reset) begin
      if (word_out_valid && word_out_ready)
        got_q.push_back({word_out_last, word_out});
      if (frame_done) n_done++;
      if (frame_error) n_err++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data       = b;
    rx_data_valid = 1'b1;
    tick(hold);
    rx_data_valid = 1'b0;
    tick(1);
  endtask

  // Sends fb; with the checksum option, appends the sum of header+payload.
  task automatic send_frame();
    logic [7:0] s;
    bit started;
    s = 8'd0;
    started = 1'b0;
    foreach (fb[i]) begin
      send_byte(fb[i], 1);
      if (started || fb[i] != 8'd0) begin
        started = 1'b1;
        s = s + fb[i];
      end
    end
`ifdef RX_FRAME_CHECKSUM_EN
    if (started) send_byte(s, 1);
`endif
  endtask

  function automatic logic [7:0] fill_byte(input int w, input int j);
    return 8'(w * 16 + j + 1);
  endfunction

  initial begin
    logic [7:0]  s;
    logic [32:0] e;
    n_tests = 0;
    n_fail  = 0;
    mon_clr = 1'b0;
    reset = 1'b1;
    rx_data = 8'd0;
    rx_data_valid = 1'b0;
    word_out_ready = 1'b1;

    vt[0].b  = '{8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 0, 0, 0, 0, 0};
    vt[0].nb = 5; vt[0].nw = 1; vt[0].ndone = 1;
    vt[0].w  = '{33'h1_1122_3344, 33'h0};
    vt[1].b  = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 0, 0, 0, 0};
    vt[1].nb = 6; vt[1].nw = 1; vt[1].ndone = 1;
    vt[1].w  = '{33'h1_DDCC_BBAA, 33'h0};
    vt[2].b  = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'h07, 8'h08, 0};
    vt[2].nb = 9; vt[2].nw = 2; vt[2].ndone = 1;
    vt[2].w  = '{33'h0_0403_0201, 33'h1_0807_0605};
    vt[3].b  = '{8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3].nb = 1; vt[3].nw = 0; vt[3].ndone = 0;
    vt[3].w  = '{33'h0, 33'h0};

    tick(3);
    reset = 1'b0;
    chk("rst_valid", 64'(word_out_valid), 64'd0);
    chk("rst_ready", 64'(rx_ready), 64'd1);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_err", 64'(frame_error), 64'd0);

    for (int i = 0; i < 4; i++) begin
      clr();
      fb.delete();
      for (int j = 0; j < vt[i].nb; j++) fb.push_back(vt[i].b[j]);
      send_frame();
      tick(4);
      chk($sformatf("v%0d_nwords", i), 64'(got_q.size()), 64'(vt[i].nw));
      for (int k = 0; k < vt[i].nw; k++)
        chk($sformatf("v%0d_word%0d", i, k),
            (k < got_q.size()) ? 64'(got_q[k]) : 64'hDEAD,
            64'(vt[i].w[k]));
      chk($sformatf("v%0d_done", i), 64'(n_done), 64'(vt[i].ndone));
      chk($sformatf("v%0d_err", i), 64'(n_err), 64'd0);
    end

    // Long valid level: the held byte must land in exactly one lane.
    clr();
    send_byte(8'h01, 1);
    send_byte(8'h02, 16);
    send_byte(8'h03, 1);
    send_byte(8'h04, 1);
    send_byte(8'h05, 1);
`ifdef RX_FRAME_CHECKSUM_EN
    send_byte(8'h0F, 1);
`endif
    tick(4);
    chk("hold_nwords", 64'(got_q.size()), 64'd1);
    chk("hold_word", (got_q.size() > 0) ? 64'(got_q[0]) : 64'hDEAD,
        64'h1_0504_0302);
    chk("hold_done", 64'(n_done), 64'd1);

    // Fill the FIFO with the consumer stalled, then overflow it.
    word_out_ready = 1'b0;
    clr();
    s = 8'h08;
    send_byte(8'h08, 1);
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 4; j++) begin
        send_byte(fill_byte(w, j), 1);
        s = s + fill_byte(w, j);
      end
      chk($sformatf("fill_ready%0d", w + 1), 64'(rx_ready),
          64'((w + 1) <= 6));
    end
`ifdef RX_FRAME_CHECKSUM_EN
    send_byte(s, 1);
`endif
    tick(2);
    chk("fill_valid", 64'(word_out_valid), 64'd1);
    chk("fill_done", 64'(n_done), 64'd1);
    fb.delete();
    fb.push_back(8'h01);
    fb.push_back(8'hE0);
    fb.push_back(8'hE1);
    fb.push_back(8'hE2);
    fb.push_back(8'hE3);
    send_frame();
    tick(2);
    chk("drop_done", 64'(n_done), 64'd2);
    word_out_ready = 1'b1;
    tick(12);
    chk("drain_n", 64'(got_q.size()), 64'd8);
    for (int w = 0; w < 8; w++) begin
      e = {(w == 7) ? 1'b1 : 1'b0, fill_byte(w, 3), fill_byte(w, 2),
           fill_byte(w, 1), fill_byte(w, 0)};
      chk($sformatf("drain_w%0d", w),
          (w < got_q.size()) ? 64'(got_q[w]) : 64'hDEAD, 64'(e));
    end
    chk("drain_valid", 64'(word_out_valid), 64'd0);

    // Reset mid-frame with a word already queued.
    word_out_ready = 1'b0;
    clr();
    fb.delete();
    fb.push_back(8'h01);
    fb.push_back(8'hAA);
    fb.push_back(8'hBB);
    fb.push_back(8'hCC);
    fb.push_back(8'hDD);
    send_frame();
    chk("pre_rst_valid", 64'(word_out_valid), 64'd1);
    send_byte(8'h02, 1);
    send_byte(8'h10, 1);
    send_byte(8'h20, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_rst_valid", 64'(word_out_valid), 64'd0);
    chk("mid_rst_ready", 64'(rx_ready), 64'd1);
    word_out_ready = 1'b1;
    clr();
    fb.delete();
    fb.push_back(8'h01);
    fb.push_back(8'h01);
    fb.push_back(8'h02);
    fb.push_back(8'h03);
    fb.push_back(8'h04);
    send_frame();
    tick(4);
    chk("post_rst_n", 64'(got_q.size()), 64'd1);
    chk("post_rst_word", (got_q.size() > 0) ? 64'(got_q[0]) : 64'hDEAD,
        64'h1_0403_0201);

`ifdef RX_FRAME_CHECKSUM_EN
    clr();
    send_byte(8'h01, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    tick(3);
    chk("csum_ok_done", 64'(n_done), 64'd1);
    chk("csum_ok_err", 64'(n_err), 64'd0);
    clr();
    send_byte(8'h01, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h03, 1);
    tick(3);
    chk("csum_bad_done", 64'(n_done), 64'd1);
    chk("csum_bad_err", 64'(n_err), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
